// File: rtl/interrupt_ctrl_pkg.sv
// Shared processor definitions for the interrupt controller: FSM state
// encoding and the default drain length / interrupt vector location.
package interrupt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SAVE,
        ST_VECTOR,
        ST_ISR,
        ST_RESTORE
    } irq_state_t;

    localparam int         DRAIN_CYCLES_DEF = 3;
    localparam logic [7:0] INT_VEC_DEF      = 8'h01;

    // Drain counter width; covers the legal DRAIN_CYCLES range 1..15.
    localparam int         CNT_W            = 4;

endpackage

// File: rtl/interrupt_ctrl_if.sv
// Pipeline <-> interrupt controller signal bundle. The controller takes
// the slave view; the pipeline (or a bench) takes the master view.
interface interrupt_ctrl_if #(
    parameter int PC_W = 8
);
    logic            irq;
    logic            rti_dec;
    logic [PC_W-1:0] pc_next;
    logic            stall_fetch;
    logic            intr;
    logic            rti;
    logic            push_en;
    logic [PC_W-1:0] push_data;
    logic            vec_load;
    logic [PC_W-1:0] vec_addr;
    logic            flush;
    logic            in_isr;
    logic            spurious_rti;

    modport slave (
        input  irq, rti_dec, pc_next,
        output stall_fetch, intr, rti, push_en, push_data,
               vec_load, vec_addr, flush, in_isr, spurious_rti
    );

    modport master (
        output irq, rti_dec, pc_next,
        input  stall_fetch, intr, rti, push_en, push_data,
               vec_load, vec_addr, flush, in_isr, spurious_rti
    );
endinterface

// File: rtl/interrupt_ctrl_irq_sync.sv
// Two-flop synchroniser for the asynchronous irq level plus a rising-edge
// detector on the synchronised signal. Reset clears all three flops so an
// irq already high at reset release is seen as a fresh edge.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    output logic o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability chain followed by a one-cycle history flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_irq;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt entry/exit sequencer: drains fetch, shadows flags and pushes
// the return PC, vectors through M[INT_VEC], then waits for RTI to restore.
// One shadow level only: requests arriving outside IDLE stay pending.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int              PC_W         = 8,
    parameter int              DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter logic [PC_W-1:0] INT_VEC      = PC_W'(INT_VEC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    interrupt_ctrl_if.slave    bus
);
    irq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_ret_pc;
    logic             r_pending;
    logic             r_stall;
    logic             r_intr;
    logic             r_rti;
    logic             r_push_en;
    logic [PC_W-1:0]  r_push_data;
    logic             r_vec_load;
    logic [PC_W-1:0]  r_vec_addr;
    logic             r_flush;
    logic             r_in_isr;
    logic             r_spur;
    logic             w_rise;
    logic             w_take;

    irq_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_irq  (bus.irq),
        .o_rise (w_rise)
    );

    assign w_take = (r_state == ST_IDLE) && r_pending;

    // Sequencer with registered outputs: each strobe is set on the edge that
    // enters its state, so outputs line up exactly with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ret_pc    <= '0;
            r_pending   <= 1'b0;
            r_stall     <= 1'b0;
            r_intr      <= 1'b0;
            r_rti       <= 1'b0;
            r_push_en   <= 1'b0;
            r_push_data <= '0;
            r_vec_load  <= 1'b0;
            r_vec_addr  <= '0;
            r_flush     <= 1'b0;
            r_in_isr    <= 1'b0;
            r_spur      <= 1'b0;
        end else begin
            // A new edge wins over the clear, so it is never lost.
            r_pending   <= w_rise | (r_pending & ~w_take);
            r_intr      <= 1'b0;
            r_rti       <= 1'b0;
            r_push_en   <= 1'b0;
            r_push_data <= '0;
            r_vec_load  <= 1'b0;
            r_vec_addr  <= '0;
            r_flush     <= 1'b0;
            r_spur      <= bus.rti_dec && (r_state != ST_ISR);
            case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        r_ret_pc <= bus.pc_next;
                        r_cnt    <= CNT_W'(DRAIN_CYCLES - 1);
                        r_stall  <= 1'b1;
                        r_state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_intr      <= 1'b1;
                        r_push_en   <= 1'b1;
                        r_push_data <= r_ret_pc;
                        r_state     <= ST_SAVE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_SAVE: begin
                    r_stall    <= 1'b0;
                    r_vec_load <= 1'b1;
                    r_vec_addr <= INT_VEC;
                    r_flush    <= 1'b1;
                    r_state    <= ST_VECTOR;
                end
                ST_VECTOR: begin
                    r_in_isr <= 1'b1;
                    r_state  <= ST_ISR;
                end
                ST_ISR: begin
                    if (bus.rti_dec) begin
                        r_rti   <= 1'b1;
                        r_state <= ST_RESTORE;
                    end
                end
                ST_RESTORE: begin
                    r_in_isr <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stall_fetch  = r_stall;
    assign bus.intr         = r_intr;
    assign bus.rti          = r_rti;
    assign bus.push_en      = r_push_en;
    assign bus.push_data    = r_push_data;
    assign bus.vec_load     = r_vec_load;
    assign bus.vec_addr     = r_vec_addr;
    assign bus.flush        = r_flush;
    assign bus.in_isr       = r_in_isr;
    assign bus.spurious_rti = r_spur;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl. Expected strobe events (kind, cycle,
// data) are queued when stimulus is applied and popped by a monitor as the
// DUT emits them; level checks are made inline in the stimulus sequence.
module tb_interrupt_ctrl;

    localparam int PC_W = 8;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] cyc;
        logic [7:0]  data;
    } ev_t;

    localparam logic [1:0] K_INTR = 2'd0;
    localparam logic [1:0] K_VEC  = 2'd1;
    localparam logic [1:0] K_RTI  = 2'd2;
    localparam logic [1:0] K_SPUR = 2'd3;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    ev_t  sb[$];

    interrupt_ctrl_if #(.PC_W(PC_W)) bus ();

    interrupt_ctrl #(
        .PC_W         (PC_W),
        .DRAIN_CYCLES (3),
        .INT_VEC      (8'h01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input int c, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = 16'(c);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag, input logic [1:0] k, input logic [7:0] d);
        ev_t got;
        ev_t want;
        got.kind = k;
        got.cyc  = 16'(cyc);
        got.data = d;
        if (sb.size() == 0) begin
            want = '1;
        end else begin
            want = sb.pop_front();
        end
        check(tag, 32'(got), 32'(want));
    endtask

    // Strobe monitor plus per-cycle invariants.
    always @(negedge clk) begin
        if (bus.intr) pop_cmp("intr_event", K_INTR, bus.push_data);
        if (bus.vec_load) pop_cmp("vec_event", K_VEC, bus.vec_addr);
        if (bus.rti) pop_cmp("rti_event", K_RTI, 8'h00);
        if (bus.spurious_rti) pop_cmp("spur_event", K_SPUR, 8'h00);
        check("intr_rti_excl", 32'(bus.intr & bus.rti), 32'd0);
        check("push_match", {31'd0, bus.push_en}, {31'd0, bus.intr});
        check("flush_match", {31'd0, bus.flush}, {31'd0, bus.vec_load});
        if (!bus.push_en) check("push_data_idle", 32'(bus.push_data), 32'd0);
        if (!bus.vec_load) check("vec_addr_idle", 32'(bus.vec_addr), 32'd0);
    end

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {19'd0, bus.stall_fetch, bus.intr, bus.rti, bus.push_en,
                    bus.vec_load, bus.flush, bus.in_isr, bus.spurious_rti,
                    bus.push_data | bus.vec_addr}, 32'd0);
    endtask

    initial begin
        cyc         = 0;
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b0;
        bus.irq     = 1'b0;
        bus.rti_dec = 1'b0;
        bus.pc_next = 8'h00;

        // Reset state.
        at_cyc(1);
        check_all_zero("reset_outputs");
        at_cyc(2);
        rst = 1'b1;

        // Basic service: irq sampled at cycle 10.
        at_cyc(9);
        bus.pc_next = 8'h2A;
        bus.irq     = 1'b1;
        expect_ev(K_INTR, 16, 8'h2A);
        expect_ev(K_VEC, 17, 8'h01);
        at_cyc(12);
        bus.irq = 1'b0;
        check("stall_before_drain", 32'(bus.stall_fetch), 32'd0);
        at_cyc(13);
        check("stall_drain_start", 32'(bus.stall_fetch), 32'd1);
        at_cyc(16);
        check("stall_in_save", 32'(bus.stall_fetch), 32'd1);
        at_cyc(17);
        check("stall_in_vector", 32'(bus.stall_fetch), 32'd0);
        check("in_isr_vector", 32'(bus.in_isr), 32'd0);
        at_cyc(18);
        check("in_isr_entry", 32'(bus.in_isr), 32'd1);

        // Nested request inside ISR is held until after RESTORE.
        at_cyc(19);
        bus.irq = 1'b1;
        at_cyc(22);
        bus.irq = 1'b0;
        at_cyc(25);
        bus.pc_next = 8'h3C;
        at_cyc(30);
        bus.rti_dec = 1'b1;
        expect_ev(K_RTI, 31, 8'h00);
        expect_ev(K_INTR, 36, 8'h3C);
        expect_ev(K_VEC, 37, 8'h01);
        at_cyc(31);
        bus.rti_dec = 1'b0;
        check("in_isr_restore", 32'(bus.in_isr), 32'd1);
        at_cyc(32);
        check("in_isr_idle", 32'(bus.in_isr), 32'd0);
        check("stall_idle", 32'(bus.stall_fetch), 32'd0);
        at_cyc(33);
        check("stall_nested_drain", 32'(bus.stall_fetch), 32'd1);
        at_cyc(40);
        bus.rti_dec = 1'b1;
        expect_ev(K_RTI, 41, 8'h00);
        at_cyc(41);
        bus.rti_dec = 1'b0;

        // Spurious RTI from IDLE.
        at_cyc(45);
        bus.rti_dec = 1'b1;
        expect_ev(K_SPUR, 46, 8'h00);
        at_cyc(46);
        bus.rti_dec = 1'b0;
        at_cyc(47);
        check("spur_state_idle", {30'd0, bus.in_isr, bus.stall_fetch}, 32'd0);

        // Three edges while busy collapse into one later service.
        at_cyc(49);
        bus.pc_next = 8'h55;
        bus.irq     = 1'b1;
        expect_ev(K_INTR, 56, 8'h55);
        expect_ev(K_VEC, 57, 8'h01);
        at_cyc(52);
        bus.irq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_cyc(59 + 2 * i);
            bus.irq = 1'b1;
            at_cyc(60 + 2 * i);
            bus.irq = 1'b0;
            bus.pc_next = 8'h77;
        end
        at_cyc(70);
        bus.rti_dec = 1'b1;
        expect_ev(K_RTI, 71, 8'h00);
        expect_ev(K_INTR, 76, 8'h77);
        expect_ev(K_VEC, 77, 8'h01);
        at_cyc(71);
        bus.rti_dec = 1'b0;
        at_cyc(80);
        bus.rti_dec = 1'b1;
        expect_ev(K_RTI, 81, 8'h00);
        at_cyc(81);
        bus.rti_dec = 1'b0;
        at_cyc(90);
        check("collapse_queue_empty", 32'(sb.size()), 32'd0);

        // Reset mid-DRAIN with irq held high; restart after release.
        at_cyc(99);
        bus.pc_next = 8'h99;
        bus.irq     = 1'b1;
        at_cyc(104);
        check("drain_before_reset", 32'(bus.stall_fetch), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        at_cyc(106);
        check_all_zero("reset_held_outputs");
        rst = 1'b1;
        expect_ev(K_INTR, 113, 8'h99);
        expect_ev(K_VEC, 114, 8'h01);
        at_cyc(115);
        check("in_isr_after_reset", 32'(bus.in_isr), 32'd1);
        at_cyc(116);
        bus.irq = 1'b0;
        at_cyc(120);
        bus.rti_dec = 1'b1;
        expect_ev(K_RTI, 121, 8'h00);
        at_cyc(121);
        bus.rti_dec = 1'b0;
        at_cyc(130);
        check("final_queue_empty", 32'(sb.size()), 32'd0);
        check("final_idle", {30'd0, bus.in_isr, bus.stall_fetch}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 8, PC/address width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, cycles of fetch stall before flags are saved (range 1..15).
REQ-003 SHALL have parameter INT_VEC, default 8'h01, memory address holding the ISR start address.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port irq  input  1  external interrupt request, asynchronous level.
REQ-007 SHALL have port rti_dec  input  1  RTI decoded in the pipeline, one-cycle pulse.
REQ-008 SHALL have port pc_next  input  PC_W  return address, i.e. the next PC, from fetch.
REQ-009 SHALL have port stall_fetch  output  1  freezes fetch and the PC.
REQ-010 SHALL have port intr  output  1  one-cycle pulse to CCR: shadow the flags.
REQ-011 SHALL have port rti  output  1  one-cycle pulse to CCR: restore the flags.
REQ-012 SHALL have ports push_en (output 1) and push_data (output PC_W), stack push of the return PC.
REQ-013 SHALL have ports vec_load (output 1), vec_addr (output PC_W) and flush (output 1); these redirect fetch to M[INT_VEC] and kill younger instructions.
REQ-014 SHALL have ports in_isr (output 1) and spurious_rti (output 1, one-cycle pulse).

Function
REQ-015 SHALL pass irq through a 2-flop synchroniser; a rising edge of the synchronised signal SHALL set a pending flag.
REQ-016 SHALL implement states IDLE, DRAIN, SAVE, VECTOR, ISR, RESTORE.
REQ-017 IDLE: when pending=1, SHALL capture pc_next into ret_pc, clear pending, load the drain counter with DRAIN_CYCLES-1 and go to DRAIN.
REQ-018 DRAIN: stall_fetch=1; SHALL decrement the counter each cycle and go to SAVE on the cycle the counter reads 0, so DRAIN lasts exactly DRAIN_CYCLES cycles.
REQ-019 SAVE: SHALL assert intr=1, push_en=1, push_data=ret_pc and stall_fetch=1 for exactly one cycle, then go to VECTOR.
REQ-020 VECTOR: SHALL assert vec_load=1, vec_addr=INT_VEC and flush=1 for one cycle, then go to ISR.
REQ-021 ISR: in_isr=1; rti_dec=1 SHALL move the FSM to RESTORE.
REQ-022 RESTORE: SHALL assert rti=1 for one cycle with in_isr still 1, then go to IDLE.
REQ-023 Entry latency: an irq rising edge SHALL produce intr exactly 2 (sync) + 1 (IDLE) + DRAIN_CYCLES cycles later.
REQ-024 Nesting: an irq edge outside IDLE SHALL only set pending, and SHALL be serviced from IDLE after RESTORE (single CCR shadow level).
REQ-025 Multiple irq edges while pending=1 SHALL collapse into one service.
REQ-026 rti_dec outside ISR SHALL NOT assert rti; it SHALL pulse spurious_rti for one cycle and leave the state unchanged.
REQ-027 intr and rti SHALL never be high in the same cycle; each SHALL be at most one cycle wide.
REQ-028 push_data and vec_addr SHALL be 0 when not strobed.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE and clear the synchroniser, pending, counter and ret_pc.
REQ-030 rst=0 SHALL drive every output to 0, including mid-DRAIN and mid-ISR, with no intr or rti pulse emitted.
REQ-031 After reset release, a held-high irq SHALL count as one rising edge.

Structure
REQ-032 The state enum and the default values of INT_VEC and DRAIN_CYCLES SHALL live in the shared processor package.
REQ-033 The synchroniser plus edge detector SHALL be a sub-module, irq_sync.
REQ-034 All state SHALL use a single clk domain with asynchronous active-low rst.

Verification
REQ-035 irq 0->1 at cycle 10, DRAIN_CYCLES=3, pc_next=8'h2A -> intr and push_en with push_data=8'h2A at cycle 16; vec_load with vec_addr=8'h01 at 17; in_isr from 18.
REQ-036 In ISR, rti_dec at cycle 30 -> rti=1 at cycle 31; in_isr=0 and state IDLE at 32; CCR flags restored.
REQ-037 Second irq edge at cycle 20 (inside ISR) -> no intr until after RESTORE; then exactly one more service with the new pc_next.
REQ-038 rti_dec in IDLE -> spurious_rti one cycle, rti stays 0, state IDLE.
REQ-039 rst low during DRAIN (cycle 14) -> outputs 0 immediately, no intr; with irq held high, service restarts after release.
REQ-040 Three irq pulses before IDLE samples pending -> exactly one intr pulse.
